// File: rtl/csc_row_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csc_row_gen_if : parameter-side and storage-side handshake bundle for the  |
// |                  CSC first-row generator                                   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
interface csc_row_gen_if #(
  parameter int MAT_RANK = 256,
  parameter int NTAP     = 2,
  parameter int DW       = 32
) ();
  localparam int INDEX_W = $clog2(MAT_RANK);
  localparam int NNZ_W   = $clog2(2*NTAP+1);

  logic [DW-1:0]             s_val_r;
  logic [DW-1:0]             s_val_i;
  logic [NTAP*DW-1:0]        a_val_r;
  logic [NTAP*DW-1:0]        a_val_i;
  logic [NTAP*INDEX_W-1:0]   z_idx;
  logic                      in_vld;
  logic                      in_rdy;
  logic [2*NTAP*INDEX_W-1:0] col_index;
  logic [2*NTAP*DW-1:0]      val_r;
  logic [2*NTAP*DW-1:0]      val_i;
  logic [NNZ_W-1:0]          nnz;
  logic                      err;
  logic                      out_vld;
  logic                      out_rdy;

  modport master (
    output s_val_r, s_val_i, a_val_r, a_val_i, z_idx, in_vld, out_rdy,
    input  in_rdy, col_index, val_r, val_i, nnz, err, out_vld
  );

  modport slave (
    input  s_val_r, s_val_i, a_val_r, a_val_i, z_idx, in_vld, out_rdy,
    output in_rdy, col_index, val_r, val_i, nnz, err, out_vld
  );
endinterface
`default_nettype wire

// File: rtl/csc_row_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csc_row_gen : builds the sorted, duplicate-merged first-row non-zero list  |
// |               of a CSC matrix from NTAP scaled taps plus their mirrors     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module csc_row_gen #(
  parameter int              MAT_RANK   = 256,
  parameter int              NTAP       = 2,
  parameter int              DW         = 32,
  parameter int              FRAC       = 17,
  parameter logic [NTAP-1:0] MIRROR_NEG = NTAP'(2'b10)
) (
  input  logic        clk,
  input  logic        rst_n,
  csc_row_gen_if.slave bus
);
  localparam int INDEX_W = $clog2(MAT_RANK);
  localparam int NNZ_W   = $clog2(2*NTAP+1);
  localparam int CNT_W   = $clog2(NTAP+1);
  localparam int K_W     = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int PROD_W  = 2*DW + 1;
  localparam int ACC_W   = PROD_W + $clog2(NTAP);
  localparam int NSLOT   = 2*NTAP;

  localparam logic [INDEX_W-1:0] c_HALF   = INDEX_W'(MAT_RANK/2);
  localparam logic [K_W-1:0]     c_K_LAST = K_W'(NTAP-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INS  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [K_W-1:0]          r_k;
  logic [CNT_W-1:0]        r_m;
  logic signed [DW-1:0]    r_sr;
  logic signed [DW-1:0]    r_si;
  logic [NTAP*DW-1:0]      r_ar;
  logic [NTAP*DW-1:0]      r_ai;
  logic [NTAP*INDEX_W-1:0] r_z;

  // Sorted list: entries 0..r_m-1 are valid, ascending by column
  logic [INDEX_W-1:0]      r_lz [NTAP];
  logic signed [ACC_W-1:0] r_pr [NTAP];
  logic signed [ACC_W-1:0] r_pi [NTAP];
  logic signed [ACC_W-1:0] r_qr [NTAP];
  logic signed [ACC_W-1:0] r_qi [NTAP];

  logic [NSLOT*INDEX_W-1:0] r_col;
  logic [NSLOT*DW-1:0]      r_vr;
  logic [NSLOT*DW-1:0]      r_vi;
  logic [NNZ_W-1:0]         r_nnz;
  logic                     r_err;

  logic                     w_accept;

  // ---------------------------------------------------------------------------
  // Current tap product
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0]     w_ar;
  logic signed [DW-1:0]     w_ai;
  logic signed [PROD_W-1:0] w_xr;
  logic signed [PROD_W-1:0] w_xi;
  logic signed [PROD_W-1:0] w_yr;
  logic signed [PROD_W-1:0] w_yi;
  logic signed [PROD_W-1:0] w_prod_r;
  logic signed [PROD_W-1:0] w_prod_i;
  logic signed [ACC_W-1:0]  w_pr;
  logic signed [ACC_W-1:0]  w_pi;
  logic signed [ACC_W-1:0]  w_qr;
  logic signed [ACC_W-1:0]  w_qi;
  logic [INDEX_W-1:0]       w_z;
  logic                     w_drop;

  assign w_ar     = $signed(r_ar[r_k*DW +: DW]);
  assign w_ai     = $signed(r_ai[r_k*DW +: DW]);
  assign w_xr     = PROD_W'(w_ar);
  assign w_xi     = PROD_W'(w_ai);
  assign w_yr     = PROD_W'(r_sr);
  assign w_yi     = PROD_W'(r_si);
  assign w_prod_r = w_xr * w_yr - w_xi * w_yi;
  assign w_prod_i = w_xr * w_yi + w_xi * w_yr;
  assign w_pr     = ACC_W'(w_prod_r);
  assign w_pi     = ACC_W'(w_prod_i);
  assign w_qr     = MIRROR_NEG[r_k] ? -w_pr : w_pr;
  assign w_qi     = MIRROR_NEG[r_k] ? -w_pi : w_pi;
  assign w_z      = r_z[r_k*INDEX_W +: INDEX_W];
  assign w_drop   = (w_z >= c_HALF);

  // ---------------------------------------------------------------------------
  // List search: matching entry, or insertion point = count of smaller columns
  // ---------------------------------------------------------------------------
  logic             w_hit;
  logic [K_W-1:0]   w_hit_idx;
  logic [CNT_W-1:0] w_pos;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_pos     = '0;
    for (int j = 0; j < NTAP; j++) begin
      if (CNT_W'(j) < r_m) begin
        if (r_lz[j] == w_z) begin
          w_hit     = 1'b1;
          w_hit_idx = K_W'(j);
        end else if (r_lz[j] < w_z) begin
          w_pos = w_pos + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot formatting: primaries, then mirrors, then zero padding
  // ---------------------------------------------------------------------------
  logic [NSLOT*INDEX_W-1:0] w_col;
  logic [NSLOT*DW-1:0]      w_vr;
  logic [NSLOT*DW-1:0]      w_vi;
  logic signed [ACC_W-1:0]  w_tr;
  logic signed [ACC_W-1:0]  w_ti;
  logic [K_W-1:0]           w_src;
  int                       w_mi;

  always_comb begin
    w_col = '0;
    w_vr  = '0;
    w_vi  = '0;
    w_tr  = '0;
    w_ti  = '0;
    w_src = '0;
    w_mi  = int'(r_m);
    for (int j = 0; j < NSLOT; j++) begin
      if (j < w_mi) begin
        w_src                      = K_W'(j);
        w_tr                       = r_pr[w_src] >>> FRAC;
        w_ti                       = r_pi[w_src] >>> FRAC;
        w_col[j*INDEX_W +: INDEX_W] = r_lz[w_src];
        w_vr[j*DW +: DW]           = w_tr[DW-1:0];
        w_vi[j*DW +: DW]           = w_ti[DW-1:0];
      end else if (j < 2*w_mi) begin
        w_src                      = K_W'(j - w_mi);
        w_tr                       = r_qr[w_src] >>> FRAC;
        w_ti                       = r_qi[w_src] >>> FRAC;
        w_col[j*INDEX_W +: INDEX_W] = r_lz[w_src] + c_HALF;
        w_vr[j*DW +: DW]           = w_tr[DW-1:0];
        w_vi[j*DW +: DW]           = w_ti[DW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.in_rdy  = 1'b0;
    bus.out_vld = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_rdy = 1'b1;
        if (bus.in_vld) begin
          w_accept = 1'b1;
          w_next   = S_INS;
        end
      end
      S_INS: begin
        if (r_k == c_K_LAST) begin
          w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_next = S_OUT;
      end
      S_OUT: begin
        bus.out_vld = 1'b1;
        if (bus.out_rdy) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_m   <= '0;
      r_sr  <= '0;
      r_si  <= '0;
      r_ar  <= '0;
      r_ai  <= '0;
      r_z   <= '0;
      for (int j = 0; j < NTAP; j++) begin
        r_lz[j] <= '0;
        r_pr[j] <= '0;
        r_pi[j] <= '0;
        r_qr[j] <= '0;
        r_qi[j] <= '0;
      end
      r_col <= '0;
      r_vr  <= '0;
      r_vi  <= '0;
      r_nnz <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sr  <= $signed(bus.s_val_r);
        r_si  <= $signed(bus.s_val_i);
        r_ar  <= bus.a_val_r;
        r_ai  <= bus.a_val_i;
        r_z   <= bus.z_idx;
        r_k   <= '0;
        r_m   <= '0;
        r_err <= 1'b0;
      end

      if (r_state == S_INS) begin
        r_k <= r_k + 1'b1;
        if (w_drop) begin
          r_err <= 1'b1;
        end else if (w_hit) begin
          r_pr[w_hit_idx] <= r_pr[w_hit_idx] + w_pr;
          r_pi[w_hit_idx] <= r_pi[w_hit_idx] + w_pi;
          r_qr[w_hit_idx] <= r_qr[w_hit_idx] + w_qr;
          r_qi[w_hit_idx] <= r_qi[w_hit_idx] + w_qi;
        end else begin
          for (int j = 0; j < NTAP; j++) begin
            if (CNT_W'(j) == w_pos) begin
              r_lz[j] <= w_z;
              r_pr[j] <= w_pr;
              r_pi[j] <= w_pi;
              r_qr[j] <= w_qr;
              r_qi[j] <= w_qi;
            end
          end
          // Entries at or above the insertion point move up one slot
          for (int j = 1; j < NTAP; j++) begin
            if ((CNT_W'(j) > w_pos) && (CNT_W'(j) <= r_m)) begin
              r_lz[j] <= r_lz[j-1];
              r_pr[j] <= r_pr[j-1];
              r_pi[j] <= r_pi[j-1];
              r_qr[j] <= r_qr[j-1];
              r_qi[j] <= r_qi[j-1];
            end
          end
          r_m <= r_m + 1'b1;
        end
      end

      if (r_state == S_FIN) begin
        r_col <= w_col;
        r_vr  <= w_vr;
        r_vi  <= w_vi;
        r_nnz <= NNZ_W'({r_m, 1'b0});
      end
    end
  end

  assign bus.col_index = r_col;
  assign bus.val_r     = r_vr;
  assign bus.val_i     = r_vi;
  assign bus.nnz       = r_nnz;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_csc_row_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_csc_row_gen : directed and random transactions for csc_row_gen with a   |
// |                  behavioural scoreboard                                    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_csc_row_gen;
  localparam int              N     = 256;
  localparam int              NT    = 2;
  localparam int              DW    = 32;
  localparam int              FRAC  = 17;
  localparam int              IW    = 8;
  localparam int              NS    = 2*NT;
  localparam int              NNZ_W = 3;
  localparam int              AW    = 2*DW + 8;
  localparam logic [NT-1:0]   MNEG  = 2'b10;

  typedef struct {
    logic [NS*IW-1:0] col;
    logic [NS*DW-1:0] vr;
    logic [NS*DW-1:0] vi;
    logic [NNZ_W-1:0] nnz;
    logic             err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  exp_t q[$];

  csc_row_gen_if #(.MAT_RANK(N), .NTAP(NT), .DW(DW)) bus ();

  csc_row_gen #(
    .MAT_RANK(N), .NTAP(NT), .DW(DW), .FRAC(FRAC), .MIRROR_NEG(MNEG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: accumulate per column in a dense table, then scan ascending
  function automatic exp_t model(input logic [DW-1:0] sr, input logic [DW-1:0] si,
                                 input logic [NT*DW-1:0] ar, input logic [NT*DW-1:0] ai,
                                 input logic [NT*IW-1:0] z);
    exp_t                e;
    logic                used [N/2];
    logic signed [AW-1:0] pr [N/2];
    logic signed [AW-1:0] pi [N/2];
    logic signed [AW-1:0] qr [N/2];
    logic signed [AW-1:0] qi [N/2];
    logic signed [AW-1:0] xr, xi, yr, yi, p_r, p_i, t;
    int                  zz, m, s;
    e.col = '0; e.vr = '0; e.vi = '0; e.nnz = '0; e.err = 1'b0;
    for (int c = 0; c < N/2; c++) begin
      used[c] = 1'b0; pr[c] = '0; pi[c] = '0; qr[c] = '0; qi[c] = '0;
    end
    yr = $signed(sr);
    yi = $signed(si);
    for (int k = 0; k < NT; k++) begin
      zz = int'(z[k*IW +: IW]);
      if (zz >= N/2) begin
        e.err = 1'b1;
      end else begin
        xr  = $signed(ar[k*DW +: DW]);
        xi  = $signed(ai[k*DW +: DW]);
        p_r = xr*yr - xi*yi;
        p_i = xr*yi + xi*yr;
        used[zz] = 1'b1;
        pr[zz] = pr[zz] + p_r;
        pi[zz] = pi[zz] + p_i;
        qr[zz] = qr[zz] + (MNEG[k] ? -p_r : p_r);
        qi[zz] = qi[zz] + (MNEG[k] ? -p_i : p_i);
      end
    end
    m = 0;
    for (int c = 0; c < N/2; c++) if (used[c]) m++;
    s = 0;
    for (int c = 0; c < N/2; c++) begin
      if (used[c]) begin
        e.col[s*IW +: IW]     = IW'(c);
        e.col[(s+m)*IW +: IW] = IW'(c + N/2);
        t = pr[c] >>> FRAC; e.vr[s*DW +: DW]     = t[DW-1:0];
        t = pi[c] >>> FRAC; e.vi[s*DW +: DW]     = t[DW-1:0];
        t = qr[c] >>> FRAC; e.vr[(s+m)*DW +: DW] = t[DW-1:0];
        t = qi[c] >>> FRAC; e.vi[(s+m)*DW +: DW] = t[DW-1:0];
        s++;
      end
    end
    e.nnz = NNZ_W'(2*m);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [DW-1:0] sr, input logic [DW-1:0] si,
                       input logic [NT*DW-1:0] ar, input logic [NT*DW-1:0] ai,
                       input logic [NT*IW-1:0] z);
    bus.s_val_r = sr;
    bus.s_val_i = si;
    bus.a_val_r = ar;
    bus.a_val_i = ai;
    bus.z_idx   = z;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_vld !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic collect(output exp_t e);
    e.col = '0; e.vr = '0; e.vi = '0; e.nnz = '0; e.err = 1'b0;
    chk("sb_pending", 256'(q.size() != 0), 256'(1));
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("col_index", 256'(bus.col_index), 256'(e.col));
      chk("val_r", 256'(bus.val_r), 256'(e.vr));
      chk("val_i", 256'(bus.val_i), 256'(e.vi));
      chk("nnz", 256'(bus.nnz), 256'(e.nnz));
      chk("err", 256'(bus.err), 256'(e.err));
    end
  endtask

  task automatic release_out();
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.out_rdy = 1'b0;
    chk("out_vld_clr", 256'(bus.out_vld), 256'(0));
    chk("in_rdy_back", 256'(bus.in_rdy), 256'(1));
  endtask

  task automatic run_txn(input logic [DW-1:0] sr, input logic [DW-1:0] si,
                         input logic [NT*DW-1:0] ar, input logic [NT*DW-1:0] ai,
                         input logic [NT*IW-1:0] z);
    int   lat;
    exp_t e;
    @(negedge clk);
    chk("in_rdy_idle", 256'(bus.in_rdy), 256'(1));
    apply(sr, si, ar, ai, z);
    bus.in_vld = 1'b1;
    q.push_back(model(sr, si, ar, ai, z));
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    wait_out(lat);
    chk("latency", 256'(lat), 256'(NT+1));
    collect(e);
    release_out();
  endtask

  initial begin
    int   lat;
    int   seen;
    exp_t e;
    logic [IW-1:0] z0, z1;
    clk = 1'b0;
    rst_n = 1'b0;
    nvec = 0;
    nerr = 0;
    apply('0, '0, '0, '0, '0);
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 256'(bus.in_rdy), 256'(1));
    chk("rst_out_vld", 256'(bus.out_vld), 256'(0));
    chk("rst_err", 256'(bus.err), 256'(0));
    chk("rst_nnz", 256'(bus.nnz), 256'(0));
    chk("rst_col", 256'(bus.col_index), 256'(0));
    chk("rst_val", 256'({bus.val_r, bus.val_i}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Distinct columns, delivered in reverse order
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd5});
    chk("t1_col", 256'(bus.col_index), 256'({8'd133, 8'd131, 8'd5, 8'd3}));
    chk("t1_vr", 256'(bus.val_r), 256'({32'h40000, 32'hFFFE0000, 32'h40000, 32'h20000}));

    // Duplicate column merge
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd7, 8'd7});
    chk("t2_col", 256'(bus.col_index), 256'({8'd0, 8'd0, 8'd135, 8'd7}));
    chk("t2_vr", 256'(bus.val_r), 256'({32'h0, 32'h0, 32'h20000, 32'h60000}));

    // True complex multiply
    run_txn(32'h0, 32'h20000, {32'h0, 32'h20000}, {32'h0, 32'h20000}, {8'd2, 8'd1});
    chk("t3_vr0", 256'(bus.val_r[31:0]), 256'(32'hFFFE0000));
    chk("t3_vi0", 256'(bus.val_i[31:0]), 256'(32'h20000));
    chk("t3_nnz", 256'(bus.nnz), 256'(4));

    // Mirror cancellation still counts the slot
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h20000}, '0, {8'd9, 8'd9});
    chk("t4_nnz", 256'(bus.nnz), 256'(2));
    chk("t4_mirror", 256'(bus.val_r[63:32]), 256'(0));

    // All taps out of range
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd128, 8'd255});
    chk("t5_err", 256'(bus.err), 256'(1));
    chk("t5_nnz", 256'(bus.nnz), 256'(0));

    // Backpressure with new data held on the input side
    @(negedge clk);
    apply(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd5});
    bus.in_vld = 1'b1;
    q.push_back(model(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd5}));
    @(posedge clk); #1;
    apply(32'h10000, 32'h8000, {32'h30000, 32'h11111}, {32'h4000, 32'h0}, {8'd60, 8'd10});
    wait_out(lat);
    chk("bp_latency", 256'(lat), 256'(NT+1));
    collect(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", 256'(bus.out_vld), 256'(1));
      chk("bp_in_rdy", 256'(bus.in_rdy), 256'(0));
      chk("bp_col", 256'(bus.col_index), 256'(e.col));
      chk("bp_val", 256'({bus.val_r, bus.val_i}), 256'({e.vr, e.vi}));
      chk("bp_nnz", 256'(bus.nnz), 256'(e.nnz));
    end
    q.push_back(model(32'h10000, 32'h8000, {32'h30000, 32'h11111}, {32'h4000, 32'h0}, {8'd60, 8'd10}));
    release_out();
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    chk("bp_accepted", 256'(bus.in_rdy), 256'(0));
    wait_out(lat);
    chk("bp2_latency", 256'(lat), 256'(NT+1));
    collect(e);
    release_out();

    // Range error, then a clean transaction clears err
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd200});
    chk("t6_col", 256'(bus.col_index), 256'({8'd0, 8'd0, 8'd131, 8'd3}));
    chk("t6_vr", 256'(bus.val_r), 256'({32'h0, 32'h0, 32'hFFFE0000, 32'h20000}));
    chk("t6_err", 256'(bus.err), 256'(1));
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd5});
    chk("t7_err", 256'(bus.err), 256'(0));
    run_txn(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd200});

    // Reset one cycle after the input handshake
    @(negedge clk);
    apply(32'h20000, 32'h0, {32'h20000, 32'h40000}, '0, {8'd3, 8'd5});
    bus.in_vld = 1'b1;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_out_vld", 256'(bus.out_vld), 256'(0));
    chk("mr_nnz", 256'(bus.nnz), 256'(0));
    chk("mr_col", 256'(bus.col_index), 256'(0));
    chk("mr_val", 256'({bus.val_r, bus.val_i}), 256'(0));
    chk("mr_err", 256'(bus.err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < NT+5; i++) begin
      @(posedge clk); #1;
      if (bus.out_vld === 1'b1) seen = 1;
    end
    chk("mr_no_vld", 256'(seen), 256'(0));
    chk("mr_in_rdy", 256'(bus.in_rdy), 256'(1));

    // Random transactions, alternating forced duplicate columns
    for (int i = 0; i < 8; i++) begin
      z0 = IW'($urandom_range(0, 150));
      z1 = (i % 2 == 1) ? z0 : IW'($urandom_range(0, 150));
      run_txn($urandom, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, {z1, z0});
    end

    chk("sb_drained", 256'(q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire
